axis_sideband_packer: RTL and testbench
=======================================

Name: axis_sideband_packer

Overview:
Registered, parametrised AXI-Stream sideband packer. It folds TID, TDEST, TKEEP and an input TUSER field into one output TUSER bus, and holds TID/TDEST constant for the whole packet. It sits between the MAC-side multi-port streams and single-TUSER consumers such as FIFOs and width converters. A full-throughput skid buffer on the data path breaks the timing path. The block also checks the sideband protocol and reports errors through counters.

Parameters:
DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
TID_WIDTH, 2, tid width; must be at least 1
TDEST_WIDTH, 2, tdest width; must be at least 1
USER_IN_WIDTH, 1, input tuser width; must be at least 1
TUSER_WIDTH, TID_WIDTH+TDEST_WIDTH+USER_IN_WIDTH+KEEP_WIDTH, output tuser width; derived, do not override
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  synchronous, active-low reset
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tid  in  TID_WIDTH  input stream ID
s_axis_tdest  in  TDEST_WIDTH  input destination
s_axis_tuser  in  USER_IN_WIDTH  input user bits
s_axis_tlast  in  1  input end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tuser  out  TUSER_WIDTH  packed sideband, layout {tid, tdest, tuser, tkeep}, MSB first
m_axis_tlast  out  1  output end of packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
pkt_count  out  CNT_WIDTH  packets accepted on the input (beats with tlast), wraps
id_err_count  out  CNT_WIDTH  mid-packet TID/TDEST changes, saturating
keep_err_count  out  CNT_WIDTH  non-last beats with partial tkeep, saturating
err_pulse  out  1  one-cycle pulse for any error detected this cycle

Behaviour:
- Reset (reset_n=0 at a clk edge), all registered:
  - m_axis_tvalid=0, s_axis_tready=0, skid buffer empty, in_pkt=0.
  - All counters 0, err_pulse=0; data/tuser outputs don't-care.
- Cycle after reset deasserts: s_axis_tready=1.
- A reset asserted mid-packet discards all buffered beats and the packet state. No partial-packet flush.
- Input accept: s_axis_tvalid && s_axis_tready.
- Output accept: m_axis_tvalid && m_axis_tready.
- Packet state in_pkt:
  - Set on an accepted beat with tlast=0.
  - Cleared on an accepted beat with tlast=1.
  - A single-beat packet leaves it at 0.
- Sideband capture:
  - Accepted beat with in_pkt=0: take tid/tdest from the inputs and register them in held_id/held_dest.
  - Accepted beat with in_pkt=1: the packed word uses held_id/held_dest; input tid/tdest are ignored for output.
  - tkeep and tuser are always taken from the current beat.
- id error: accepted beat, in_pkt=1, and {tid,tdest} != {held_id,held_dest}.
  - id_err_count increments, saturating at all-ones.
  - err_pulse=1 in the following cycle.
- keep error: accepted beat, tlast=0, tkeep not all ones.
  - keep_err_count increments, saturating.
  - err_pulse=1 in the following cycle.
- Both errors on the same beat: both counters increment; err_pulse=1 for one cycle.
- Counters are registered: they update on the clk edge after the accepting edge.
- pkt_count increments on every accepted tlast beat and wraps to 0 from all-ones.
- Data path is a two-register skid buffer: main register plus skid register.
  - Latency: accepted input appears on m_axis_* on the next cycle.
  - Throughput: one beat/cycle while m_axis_tready=1.
  - s_axis_tready is registered and equals !skid_valid.
  - When main holds a beat, m_axis_tready=0 and an input beat is accepted: that beat goes to skid, and s_axis_tready drops next cycle.
  - When main is output-accepted: skid moves to main (or a new input moves to main if skid is empty), and s_axis_tready rises.
  - Ordering is strictly preserved; no beat is duplicated or dropped.
- AXI-S rules on m_axis: once m_axis_tvalid=1, tdata/tuser/tlast stay stable until output accept.
- Simultaneous input and output accept with the skid empty: main is replaced by the new beat; tvalid stays 1.

Test Plan:
- Single 3-beat packet, tid=2, tdest=1, tuser=1, tkeep FF/FF/0F, m_axis_tready=1 -> output one cycle later; tuser = {2'b10,2'b01,1'b1,8'hFF} on beats 1-2 and {...,8'h0F} on the last beat; pkt_count=1; no errors.
- Same packet with tid=3 on beat 2 -> beat 2 output tid field still 2; id_err_count=1; err_pulse high exactly one cycle.
- Beat 1 tkeep=0x7F with tlast=0 -> keep_err_count=1; data passes unchanged.
- m_axis_tready toggled randomly (50%) over 1000 beats of random lengths 1-16 -> output sequence identical to input; s_axis_tready never low when skid empty; pkt_count equals number of packets.
- reset_n=0 for 1 cycle mid-packet with main and skid full -> next cycle m_axis_tvalid=0, counters 0; the next packet's first-beat tid is captured fresh.
- Force id_err_count to all-ones via 2^CNT_WIDTH errors (CNT_WIDTH=4 build) -> value holds at 15; pkt_count with CNT_WIDTH=4 wraps 15 to 0.

Source files
------------

// File: rtl/axis_sideband_packer_if.sv
// AXI-Stream bundle around the sideband packer: narrow-sideband input side, packed-TUSER output side.
// The slave modport is the packer's view; master is the upstream/downstream environment.
interface axis_sideband_packer_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH/8,
    parameter int TID_WIDTH     = 2,
    parameter int TDEST_WIDTH   = 2,
    parameter int USER_IN_WIDTH = 1,
    parameter int TUSER_WIDTH   = TID_WIDTH + TDEST_WIDTH + USER_IN_WIDTH + KEEP_WIDTH
);
    logic [DATA_WIDTH-1:0]    s_axis_tdata;
    logic [KEEP_WIDTH-1:0]    s_axis_tkeep;
    logic [TID_WIDTH-1:0]     s_axis_tid;
    logic [TDEST_WIDTH-1:0]   s_axis_tdest;
    logic [USER_IN_WIDTH-1:0] s_axis_tuser;
    logic                     s_axis_tlast;
    logic                     s_axis_tvalid;
    logic                     s_axis_tready;

    logic [DATA_WIDTH-1:0]    m_axis_tdata;
    logic [TUSER_WIDTH-1:0]   m_axis_tuser;
    logic                     m_axis_tlast;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser,
        input  s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser,
        output s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_sideband_packer.sv
// Folds tid/tdest/tuser/tkeep into one tuser bus, pins tid/tdest per packet, counts sideband errors.
// Latency: 1 cycle input to output through a main+skid register pair; full throughput.
// Backpressure: s_axis_tready is registered and drops only while the skid register holds a beat.
module axis_sideband_packer #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH/8,
    parameter int TID_WIDTH     = 2,
    parameter int TDEST_WIDTH   = 2,
    parameter int USER_IN_WIDTH = 1,
    parameter int TUSER_WIDTH   = TID_WIDTH + TDEST_WIDTH + USER_IN_WIDTH + KEEP_WIDTH,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axis_sideband_packer_if.slave axis,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] id_err_count,
    output logic [CNT_WIDTH-1:0] keep_err_count,
    output logic                 err_pulse
);
    localparam int SB_WIDTH = TID_WIDTH + TDEST_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  tdata;
        logic [TUSER_WIDTH-1:0] tuser;
        logic                   tlast;
    } beat_t;

    beat_t               in_beat;
    beat_t               main_beat;
    beat_t               skid_beat;
    logic                main_vld;
    logic                skid_vld;
    logic                s_rdy;
    logic                in_pkt;
    logic [SB_WIDTH-1:0] held_sb;
    logic [SB_WIDTH-1:0] in_sb;
    logic [SB_WIDTH-1:0] pkt_sb;
    logic                in_acc;
    logic                out_acc;
    logic                id_err;
    logic                keep_err;

    assign in_acc  = axis.s_axis_tvalid && s_rdy;
    assign out_acc = main_vld && axis.m_axis_tready;
    assign in_sb   = {axis.s_axis_tid, axis.s_axis_tdest};
    // Continuation beats reuse the sideband captured on the first beat.
    assign pkt_sb  = in_pkt ? held_sb : in_sb;

    assign id_err   = in_acc && in_pkt && (in_sb != held_sb);
    assign keep_err = in_acc && !axis.s_axis_tlast && (axis.s_axis_tkeep != {KEEP_WIDTH{1'b1}});

    always_comb begin
        in_beat       = '0;
        in_beat.tdata = axis.s_axis_tdata;
        in_beat.tuser = {pkt_sb, axis.s_axis_tuser, axis.s_axis_tkeep};
        in_beat.tlast = axis.s_axis_tlast;
    end

    // Skid buffer: main feeds the output, skid catches the one beat accepted while main stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            s_rdy    <= 1'b0;
        end else if (!main_vld || out_acc) begin
            s_rdy <= 1'b1;
            if (skid_vld) begin
                main_beat <= skid_beat;
                main_vld  <= 1'b1;
                skid_vld  <= 1'b0;
            end else begin
                main_vld <= in_acc;
                if (in_acc) begin
                    main_beat <= in_beat;
                end
            end
        end else if (in_acc) begin
            skid_beat <= in_beat;
            skid_vld  <= 1'b1;
            s_rdy     <= 1'b0;
        end else begin
            s_rdy <= !skid_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_pkt         <= 1'b0;
            held_sb        <= '0;
            pkt_count      <= '0;
            id_err_count   <= '0;
            keep_err_count <= '0;
            err_pulse      <= 1'b0;
        end else begin
            err_pulse <= id_err || keep_err;
            if (in_acc) begin
                in_pkt <= !axis.s_axis_tlast;
                if (!in_pkt) begin
                    held_sb <= in_sb;
                end
                if (axis.s_axis_tlast) begin
                    pkt_count <= pkt_count + CNT_WIDTH'(1);
                end
            end
            // Error counters saturate so a stuck source cannot make them look healthy again.
            if (id_err && (id_err_count != {CNT_WIDTH{1'b1}})) begin
                id_err_count <= id_err_count + CNT_WIDTH'(1);
            end
            if (keep_err && (keep_err_count != {CNT_WIDTH{1'b1}})) begin
                keep_err_count <= keep_err_count + CNT_WIDTH'(1);
            end
        end
    end

    assign axis.s_axis_tready = s_rdy;
    assign axis.m_axis_tvalid = main_vld;
    assign axis.m_axis_tdata  = main_beat.tdata;
    assign axis.m_axis_tuser  = main_beat.tuser;
    assign axis.m_axis_tlast  = main_beat.tlast;
endmodule

// File: tb/tb_axis_sideband_packer.sv
// Bench for axis_sideband_packer: directed vector table, corner sequences, and random traffic vs. a queue model.
module tb_axis_sideband_packer;
    localparam int DW   = 64;
    localparam int KW   = DW/8;
    localparam int IW   = 2;
    localparam int DSW  = 2;
    localparam int UW   = 1;
    localparam int TUW  = IW + DSW + UW + KW;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    axis_sideband_packer_if #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW),
        .USER_IN_WIDTH(UW), .TUSER_WIDTH(TUW)
    ) bus ();

    logic [CW-1:0] pkt_count;
    logic [CW-1:0] id_err_count;
    logic [CW-1:0] keep_err_count;
    logic          err_pulse;

    axis_sideband_packer #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW),
        .USER_IN_WIDTH(UW), .TUSER_WIDTH(TUW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .axis(bus),
        .pkt_count(pkt_count),
        .id_err_count(id_err_count),
        .keep_err_count(keep_err_count),
        .err_pulse(err_pulse)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output ready: forced level or a random coin per cycle.
    bit   rdy_mode = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_rdy = 1'b1;
    always @(negedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
    assign bus.m_axis_tready = rdy_mode ? rnd_rdy : rdy_force;

    // Reference model: beats in flight are a queue; readiness follows occupancy (<=1 beat waiting).
    typedef struct {
        logic [DW-1:0]  d;
        logic [TUW-1:0] u;
        logic           l;
    } exp_t;
    exp_t exp_q[$];
    int   m_pkt, m_id, m_keep;
    bit   m_pulse, m_in_pkt, fresh, started;
    logic [IW+DSW-1:0] m_held;

    always @(posedge clk) begin
        logic [IW+DSW-1:0] sb;
        bit id_e, keep_e, m_rdy;
        if (started) begin
            chk("m_tvalid", bus.m_axis_tvalid, exp_q.size() > 0);
            chk("s_tready", bus.s_axis_tready, !fresh && exp_q.size() < 2);
            if (exp_q.size() > 0 && bus.m_axis_tvalid) begin
                chk("m_tdata", bus.m_axis_tdata, exp_q[0].d);
                chk("m_tuser", bus.m_axis_tuser, exp_q[0].u);
                chk("m_tlast", bus.m_axis_tlast, exp_q[0].l);
            end
            chk("pkt_count", pkt_count, m_pkt);
            chk("id_err_count", id_err_count, m_id);
            chk("keep_err_count", keep_err_count, m_keep);
            chk("err_pulse", err_pulse, m_pulse);
        end
        if (!reset_n) begin
            exp_q.delete();
            m_pkt = 0; m_id = 0; m_keep = 0;
            m_pulse = 0; m_in_pkt = 0; m_held = '0;
            fresh = 1; started = 1;
        end else if (started) begin
            id_e = 0; keep_e = 0;
            m_rdy = !fresh && exp_q.size() < 2;
            if (exp_q.size() > 0 && bus.m_axis_tready) void'(exp_q.pop_front());
            if (bus.s_axis_tvalid && m_rdy) begin
                sb = {bus.s_axis_tid, bus.s_axis_tdest};
                if (!m_in_pkt) m_held = sb;
                else if (sb != m_held) id_e = 1;
                if (!bus.s_axis_tlast && bus.s_axis_tkeep != {KW{1'b1}}) keep_e = 1;
                exp_q.push_back('{bus.s_axis_tdata, {m_held, bus.s_axis_tuser, bus.s_axis_tkeep},
                                  bus.s_axis_tlast});
                if (bus.s_axis_tlast) m_pkt = (m_pkt + 1) & CMAX;
                m_in_pkt = !bus.s_axis_tlast;
                if (id_e && m_id < CMAX) m_id++;
                if (keep_e && m_keep < CMAX) m_keep++;
            end
            m_pulse = id_e || keep_e;
            fresh = 0;
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [IW-1:0] id,
                             input logic [DSW-1:0] dst, input logic [UW-1:0] u, input logic l);
        int n = 0;
        bus.s_axis_tdata = d; bus.s_axis_tkeep = k; bus.s_axis_tid = id;
        bus.s_axis_tdest = dst; bus.s_axis_tuser = u; bus.s_axis_tlast = l;
        bus.s_axis_tvalid = 1'b1;
        while (!bus.s_axis_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: s_axis_tready stayed %0b, expected 1", bus.s_axis_tready);
        end
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0]  d;
        logic [KW-1:0]  k;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dst;
        logic [UW-1:0]  u;
        logic           l;
        logic [TUW-1:0] exp_u;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int pkts, beats, len, n;
        logic [IW-1:0] rid, tid;
        logic [DSW-1:0] rdst;
        logic [KW-1:0] k;

        tbl[0] = '{64'h1111_0000_0000_0001, 8'hFF, 2'd2, 2'd1, 1'b1, 1'b0, {2'd2, 2'd1, 1'b1, 8'hFF}};
        tbl[1] = '{64'h2222_0000_0000_0002, 8'hFF, 2'd2, 2'd1, 1'b1, 1'b0, {2'd2, 2'd1, 1'b1, 8'hFF}};
        tbl[2] = '{64'h3333_0000_0000_0003, 8'h0F, 2'd2, 2'd1, 1'b1, 1'b1, {2'd2, 2'd1, 1'b1, 8'h0F}};
        tbl[3] = '{64'h4444_0000_0000_0004, 8'hFF, 2'd2, 2'd1, 1'b1, 1'b0, {2'd2, 2'd1, 1'b1, 8'hFF}};
        tbl[4] = '{64'h5555_0000_0000_0005, 8'hFF, 2'd3, 2'd1, 1'b1, 1'b0, {2'd2, 2'd1, 1'b1, 8'hFF}};
        tbl[5] = '{64'h6666_0000_0000_0006, 8'h0F, 2'd2, 2'd1, 1'b1, 1'b1, {2'd2, 2'd1, 1'b1, 8'h0F}};
        tbl[6] = '{64'h7777_0000_0000_0007, 8'h7F, 2'd1, 2'd2, 1'b0, 1'b0, {2'd1, 2'd2, 1'b0, 8'h7F}};
        tbl[7] = '{64'h8888_0000_0000_0008, 8'hFF, 2'd1, 2'd2, 1'b0, 1'b1, {2'd1, 2'd2, 1'b0, 8'hFF}};
        tbl[8] = '{64'h9999_0000_0000_0009, 8'h03, 2'd1, 2'd3, 1'b0, 1'b1, {2'd1, 2'd3, 1'b0, 8'h03}};

        bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
        bus.s_axis_tid = '0; bus.s_axis_tdest = '0; bus.s_axis_tuser = '0; bus.s_axis_tlast = 1'b0;

        // Reset and first ready cycle
        repeat (3) @(negedge clk);
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_tready", bus.s_axis_tready, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_pulse", err_pulse, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", bus.s_axis_tready, 1);

        // Directed table: one-cycle latency and packed tuser per beat
        for (int i = 0; i < 9; i++) begin
            send_beat(tbl[i].d, tbl[i].k, tbl[i].id, tbl[i].dst, tbl[i].u, tbl[i].l);
            chk("tbl_tvalid", bus.m_axis_tvalid, 1);
            chk("tbl_tdata", bus.m_axis_tdata, tbl[i].d);
            chk("tbl_tuser", bus.m_axis_tuser, tbl[i].exp_u);
            chk("tbl_tlast", bus.m_axis_tlast, tbl[i].l);
            if (i == 2) chk("tbl_pkt_after_first", pkt_count, 1);
            if (i == 2) chk("tbl_no_id_err", id_err_count, 0);
            if (i == 4) chk("tbl_id_pulse", err_pulse, 1);
            if (i == 4) chk("tbl_id_count", id_err_count, 1);
            if (i == 5) chk("tbl_id_pulse_gone", err_pulse, 0);
            if (i == 6) chk("tbl_keep_pulse", err_pulse, 1);
            if (i == 6) chk("tbl_keep_count", keep_err_count, 1);
        end
        @(negedge clk);
        chk("tbl_pkt_total", pkt_count, 4);
        chk("tbl_id_total", id_err_count, 1);
        chk("tbl_keep_total", keep_err_count, 1);

        // Fill main and skid, then reset mid-packet
        rdy_force = 1'b0;
        @(negedge clk);
        send_beat(64'hA1, 8'hFF, 2'd0, 2'd2, 1'b0, 1'b0);
        send_beat(64'hA2, 8'hFF, 2'd0, 2'd2, 1'b0, 1'b0);
        chk("full_tready", bus.s_axis_tready, 0);
        chk("full_tvalid", bus.m_axis_tvalid, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_tvalid", bus.m_axis_tvalid, 0);
        chk("midrst_pkt", pkt_count, 0);
        chk("midrst_id", id_err_count, 0);
        chk("midrst_keep", keep_err_count, 0);
        rdy_force = 1'b1;
        @(negedge clk);
        send_beat(64'hB1, 8'hFF, 2'd3, 2'd0, 1'b1, 1'b1);
        chk("fresh_tuser", bus.m_axis_tuser, {2'd3, 2'd0, 1'b1, 8'hFF});

        // Saturate id_err_count with a long packet of mismatched tid
        send_beat(64'hC0, 8'hFF, 2'd0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) send_beat(64'hC1 + i, 8'hFF, 2'd1, 2'd0, 1'b0, 1'b0);
        send_beat(64'hCF, 8'hFF, 2'd0, 2'd0, 1'b0, 1'b1);
        chk("id_sat", id_err_count, CMAX);

        // pkt_count wrap: two packets so far since reset
        for (int i = 0; i < 13; i++) send_beat(64'hD0 + i, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b1);
        chk("pkt_at_max", pkt_count, CMAX);
        send_beat(64'hDF, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b1);
        chk("pkt_wrap", pkt_count, 0);

        // Random traffic under random backpressure
        rdy_mode = 1'b1;
        pkts = 0;
        beats = 0;
        while (beats < 1000) begin
            len = $urandom_range(1, 16);
            rid = IW'($urandom);
            rdst = DSW'($urandom);
            for (int b = 0; b < len; b++) begin
                tid = ($urandom_range(0, 9) == 0) ? IW'($urandom) : rid;
                k = (b < len - 1 && $urandom_range(0, 7) == 0) ? KW'($urandom) : {KW{1'b1}};
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send_beat({$urandom, $urandom}, k, tid, rdst, UW'($urandom), b == len - 1);
                beats++;
            end
            pkts++;
        end
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("rand_pkt_count", pkt_count, pkts & CMAX);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
